// File: rtl/kugelblitz_rule_sched_if.sv
// kugelblitz_rule_sched_if: requester handshakes, monitored stream and active rule bundled for the scheduler
interface kugelblitz_rule_sched_if #(
   parameter int PORT_COUNT   = 2,
   parameter int OFFSET_WIDTH = 6,
   parameter int SEL_WIDTH    = 1
);
   logic [PORT_COUNT-1:0]              req_valid;
   logic [PORT_COUNT-1:0]              req_ready;
   logic [PORT_COUNT*OFFSET_WIDTH-1:0] req_offset;
   logic [PORT_COUNT*8-1:0]            req_data;
   logic [PORT_COUNT-1:0]              req_enable;
   logic [PORT_COUNT-1:0]              done;
   logic                               done_err;
   logic                               mon_tvalid;
   logic                               mon_tready;
   logic                               mon_tlast;
   logic                               rule_valid;
   logic [OFFSET_WIDTH-1:0]            rule_offset;
   logic [7:0]                         rule_data;
   logic [SEL_WIDTH-1:0]               rule_owner;
   logic                               busy;
   modport master (
      output req_valid, req_offset, req_data, req_enable, mon_tvalid, mon_tready, mon_tlast,
      input  req_ready, done, done_err, rule_valid, rule_offset, rule_data, rule_owner, busy
   );
   modport slave (
      input  req_valid, req_offset, req_data, req_enable, mon_tvalid, mon_tready, mon_tlast,
      output req_ready, done, done_err, rule_valid, rule_offset, rule_data, rule_owner, busy
   );
endinterface

// File: rtl/kugelblitz_rule_sched.sv
// kugelblitz_rule_sched: round-robin rule updates, committed only at frame boundaries of the monitored stream
module kugelblitz_rule_sched #(
   parameter int PORT_COUNT   = 2,
   parameter int OFFSET_WIDTH = 6,
   parameter int SEL_WIDTH    = 1,
   parameter int MAX_WAIT     = 4096
) (
   input logic                    clk,
   input logic                    rst_n,
   kugelblitz_rule_sched_if.slave bus
);
   localparam int CW = $clog2(MAX_WAIT) + 1;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t                  state_q, state_d;
   logic                    in_frame_q, in_frame_d, en_q, en_d, err_q, err_d;
   logic                    rule_valid_q, rule_valid_d, done_err_q, done_err_d;
   logic [SEL_WIDTH-1:0]    rr_q, rr_d, grant_q, grant_d, owner_q, owner_d, win;
   logic [OFFSET_WIDTH-1:0] off_q, off_d, rule_off_q, rule_off_d, win_off;
   logic [7:0]              dat_q, dat_d, rule_dat_q, rule_dat_d, win_dat;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [PORT_COUNT-1:0]   done_q, done_d;
   logic                    found, win_en, beat, boundary;
   assign beat       = bus.mon_tvalid & bus.mon_tready;
   // a first beat held without tready is not a boundary: the rule must not move under a presented beat
   assign boundary   = (!in_frame_q & !bus.mon_tvalid) | (beat & bus.mon_tlast);
   assign in_frame_d = beat ? !bus.mon_tlast : in_frame_q;
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_off = '0;
      win_dat = '0;
      win_en  = 1'b0;
      for (int j = 0; j < PORT_COUNT; j++)
         if (!found && bus.req_valid[j] && SEL_WIDTH'(j) > rr_q) begin
            win   = SEL_WIDTH'(j);
            found = 1'b1;
         end
      for (int j = 0; j < PORT_COUNT; j++)
         if (!found && bus.req_valid[j] && SEL_WIDTH'(j) <= rr_q) begin
            win   = SEL_WIDTH'(j);
            found = 1'b1;
         end
      for (int j = 0; j < PORT_COUNT; j++)
         if (win == SEL_WIDTH'(j)) begin
            win_off = bus.req_offset[j*OFFSET_WIDTH +: OFFSET_WIDTH];
            win_dat = bus.req_data[j*8 +: 8];
            win_en  = bus.req_enable[j];
         end
   end
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      off_d         = off_q;
      dat_d         = dat_q;
      en_d          = en_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      rule_valid_d  = rule_valid_q;
      rule_off_d    = rule_off_q;
      rule_dat_d    = rule_dat_q;
      owner_d       = owner_q;
      done_d        = '0;
      done_err_d    = 1'b0;
      bus.req_ready = '0;
      case (state_q)
         IDLE: if (found) begin
            bus.req_ready = PORT_COUNT'(1) << win;
            rr_d          = win;
            grant_d       = win;
            off_d         = win_off;
            dat_d         = win_dat;
            en_d          = win_en;
            cnt_d         = '0;
            state_d       = WAIT;
         end
         WAIT: if (boundary) begin
            rule_valid_d = en_q;
            rule_off_d   = off_q;
            rule_dat_d   = dat_q;
            owner_d      = grant_q;
            err_d        = 1'b0;
            state_d      = DONE;
         end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
         end else
            cnt_d = cnt_q + CW'(1);
         DONE: begin
            done_d     = PORT_COUNT'(1) << grant_q;
            done_err_d = err_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         in_frame_q   <= 1'b0;
         rr_q         <= '0;
         grant_q      <= '0;
         off_q        <= '0;
         dat_q        <= '0;
         en_q         <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         rule_valid_q <= 1'b0;
         rule_off_q   <= '0;
         rule_dat_q   <= '0;
         owner_q      <= '0;
         done_q       <= '0;
         done_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_frame_q   <= in_frame_d;
         rr_q         <= rr_d;
         grant_q      <= grant_d;
         off_q        <= off_d;
         dat_q        <= dat_d;
         en_q         <= en_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         rule_valid_q <= rule_valid_d;
         rule_off_q   <= rule_off_d;
         rule_dat_q   <= rule_dat_d;
         owner_q      <= owner_d;
         done_q       <= done_d;
         done_err_q   <= done_err_d;
      end
   assign bus.done        = done_q;
   assign bus.done_err    = done_err_q;
   assign bus.rule_valid  = rule_valid_q;
   assign bus.rule_offset = rule_off_q;
   assign bus.rule_data   = rule_dat_q;
   assign bus.rule_owner  = owner_q;
   assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_kugelblitz_rule_sched.sv
// tb_kugelblitz_rule_sched: scoreboarded bench for the frame-boundary rule scheduler
module tb_kugelblitz_rule_sched;
   localparam int MW = 16;
   typedef struct {
      logic [1:0] done;
      logic       err;
      logic       rv;
      logic [5:0] off;
      logic [7:0] dat;
      logic       owner;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic       m_rr, m_valid, m_owner;
   logic [5:0] m_off;
   logic [7:0] m_dat;
   kugelblitz_rule_sched_if #(.PORT_COUNT(2), .OFFSET_WIDTH(6), .SEL_WIDTH(1)) bus ();
   kugelblitz_rule_sched #(.PORT_COUNT(2), .OFFSET_WIDTH(6), .SEL_WIDTH(1), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1 && bus.done !== 2'b00) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL done_unexpected got done=%b err=%b want no pulse", bus.done, bus.done_err);
         end else begin
            e = sb.pop_front();
            if ({bus.done, bus.done_err, bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner}
                !== {e.done, e.err, e.rv, e.off, e.dat, e.owner}) begin
               miscompares++;
               $display("FAIL done_scoreboard got done=%b err=%b rule=%b/%0d/%h/%b want done=%b err=%b rule=%b/%0d/%h/%b",
                        bus.done, bus.done_err, bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner,
                        e.done, e.err, e.rv, e.off, e.dat, e.owner);
            end
         end
      end
   end
   task automatic set_req(input logic p, input logic [5:0] o, input logic [7:0] d, input logic e);
      if (p) begin
         bus.req_valid[1] = 1'b1; bus.req_offset[11:6] = o; bus.req_data[15:8] = d; bus.req_enable[1] = e;
      end else begin
         bus.req_valid[0] = 1'b1; bus.req_offset[5:0] = o; bus.req_data[7:0] = d; bus.req_enable[0] = e;
      end
   endtask
   task automatic push_exp(input logic [1:0] d, input logic err, input logic rv, input logic [5:0] o,
                           input logic [7:0] dt, input logic ow);
      exp_t e;
      e.done = d; e.err = err; e.rv = rv; e.off = o; e.dat = dt; e.owner = ow;
      sb.push_back(e);
      if (!err) begin
         m_valid = rv; m_off = o; m_dat = dt; m_owner = ow;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_offset = '0; bus.req_data = '0; bus.req_enable = '0;
      bus.mon_tvalid = 1'b0; bus.mon_tready = 1'b0; bus.mon_tlast = 1'b0;
      m_rr = 1'b0; m_valid = 1'b0; m_off = '0; m_dat = '0; m_owner = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.req_ready, bus.done, bus.done_err, bus.busy} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctl got ready=%b done=%b err=%b busy=%b want all 0", bus.req_ready, bus.done, bus.done_err, bus.busy);
      end
      vectors++;
      if ({bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner} !== 16'b0) begin
         miscompares++;
         $display("FAIL reset_rule got %b/%0d/%h/%b want 0/0/00/0", bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_idle_commit;
      set_req(1'b0, 6'd5, 8'hAA, 1'b1);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin
         miscompares++; $display("FAIL idle_grant got ready=%b want 01", bus.req_ready);
      end
      push_exp(2'b01, 1'b0, 1'b1, 6'd5, 8'hAA, 1'b0);
      m_rr = 1'b0;
      @(negedge clk); bus.req_valid = '0; #1;
      vectors++;
      if ({bus.req_ready, bus.busy, bus.rule_valid} !== 4'b0010) begin
         miscompares++;
         $display("FAIL idle_wait got ready=%b busy=%b rv=%b want 00/1/0", bus.req_ready, bus.busy, bus.rule_valid);
      end
      @(negedge clk); #1;
      vectors++;
      if ({bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner, bus.done} !== {1'b1, 6'd5, 8'hAA, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL idle_rule got %b/%0d/%h/%b done=%b want 1/5/aa/0 done=00",
                  bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner, bus.done);
      end
      @(negedge clk); #1;
      vectors++;
      if ({bus.done, bus.done_err} !== 3'b010) begin
         miscompares++; $display("FAIL idle_done got done=%b err=%b want 01/0", bus.done, bus.done_err);
      end
      @(negedge clk);
   endtask
   task automatic test_mid_frame;
      bus.mon_tvalid = 1'b1; bus.mon_tready = 1'b1; bus.mon_tlast = 1'b0;
      @(negedge clk);
      set_req(1'b1, 6'd9, 8'h3C, 1'b1);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b10) begin
         miscompares++; $display("FAIL frame_grant got ready=%b want 10", bus.req_ready);
      end
      push_exp(2'b10, 1'b0, 1'b1, 6'd9, 8'h3C, 1'b1);
      m_rr = 1'b1;
      @(negedge clk); bus.req_valid = '0; #1;
      vectors++;
      if ({bus.rule_offset, bus.rule_owner} !== {6'd5, 1'b0}) begin
         miscompares++; $display("FAIL frame_hold1 got off=%0d owner=%b want 5/0", bus.rule_offset, bus.rule_owner);
      end
      @(negedge clk); bus.mon_tlast = 1'b1; #1;
      vectors++;
      if ({bus.rule_offset, bus.rule_data, bus.busy} !== {6'd5, 8'hAA, 1'b1}) begin
         miscompares++;
         $display("FAIL frame_hold2 got off=%0d data=%h busy=%b want 5/aa/1", bus.rule_offset, bus.rule_data, bus.busy);
      end
      @(negedge clk); #1;
      vectors++;
      if ({bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner} !== {1'b1, 6'd9, 8'h3C, 1'b1}) begin
         miscompares++;
         $display("FAIL frame_commit got %b/%0d/%h/%b want 1/9/3c/1", bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner);
      end
      @(negedge clk); bus.mon_tvalid = 1'b0; bus.mon_tlast = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_back_to_back;
      logic [1:0] want;
      int c;
      set_req(1'b0, 6'd1, 8'h11, 1'b1);
      set_req(1'b1, 6'd2, 8'h22, 1'b1);
      for (int k = 0; k < 4; k++) begin
         c = 0;
         #1;
         while (bus.req_ready === 2'b00 && c < 8) begin
            @(negedge clk); #1; c++;
         end
         want = m_rr ? 2'b01 : 2'b10;
         vectors++;
         if (bus.req_ready !== want) begin
            miscompares++; $display("FAIL rr_grant%0d got ready=%b want %b", k, bus.req_ready, want);
         end
         if (k > 0) begin
            vectors++;
            if (c != 2) begin
               miscompares++; $display("FAIL rr_spacing%0d got %0d want 2", k, c);
            end
         end
         push_exp(want, 1'b0, 1'b1, m_rr ? 6'd1 : 6'd2, m_rr ? 8'h11 : 8'h22, ~m_rr);
         m_rr = ~m_rr;
         @(negedge clk);
      end
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
   endtask
   task automatic test_timeout;
      bus.mon_tvalid = 1'b1; bus.mon_tready = 1'b0; bus.mon_tlast = 1'b0;
      set_req(1'b0, 6'd7, 8'h77, 1'b1);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin
         miscompares++; $display("FAIL to_grant got ready=%b want 01", bus.req_ready);
      end
      push_exp(2'b01, 1'b1, m_valid, m_off, m_dat, m_owner);
      m_rr = 1'b0;
      @(negedge clk); bus.req_valid = '0;
      repeat (MW - 1) @(negedge clk);
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.rule_offset, bus.rule_data} !== {1'b1, 2'b00, m_off, m_dat}) begin
         miscompares++;
         $display("FAIL to_last_wait got busy=%b done=%b off=%0d data=%h want 1/00/%0d/%h",
                  bus.busy, bus.done, bus.rule_offset, bus.rule_data, m_off, m_dat);
      end
      @(negedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done} !== 3'b100) begin
         miscompares++; $display("FAIL to_done_state got busy=%b done=%b want 1/00", bus.busy, bus.done);
      end
      @(negedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done, bus.done_err} !== 4'b0011) begin
         miscompares++;
         $display("FAIL to_done got busy=%b done=%b err=%b want 0/01/1", bus.busy, bus.done, bus.done_err);
      end
      bus.mon_tvalid = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_clear_and_reset;
      set_req(1'b1, 6'd3, 8'h55, 1'b0);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b10) begin
         miscompares++; $display("FAIL clr_grant got ready=%b want 10", bus.req_ready);
      end
      push_exp(2'b10, 1'b0, 1'b0, 6'd3, 8'h55, 1'b1);
      m_rr = 1'b1;
      @(negedge clk); bus.req_valid = '0;
      @(negedge clk); #1;
      vectors++;
      if ({bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner} !== {1'b0, 6'd3, 8'h55, 1'b1}) begin
         miscompares++;
         $display("FAIL clr_rule got %b/%0d/%h/%b want 0/3/55/1", bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner);
      end
      repeat (3) @(negedge clk);
      bus.mon_tvalid = 1'b1; bus.mon_tready = 1'b0;
      set_req(1'b0, 6'd8, 8'h88, 1'b1);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin
         miscompares++; $display("FAIL rst_grant got ready=%b want 01", bus.req_ready);
      end
      @(negedge clk); bus.req_valid = '0; #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.req_ready, bus.done, bus.done_err, bus.busy, bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner} !== 22'b0) begin
         miscompares++;
         $display("FAIL rst_async got ready=%b done=%b err=%b busy=%b rule=%b/%0d/%h/%b want all 0", bus.req_ready, bus.done,
                  bus.done_err, bus.busy, bus.rule_valid, bus.rule_offset, bus.rule_data, bus.rule_owner);
      end
      @(negedge clk); rst_n = 1'b1; bus.mon_tvalid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         vectors++;
         if ({bus.done, bus.busy} !== 3'b000) begin
            miscompares++; $display("FAIL rst_no_done%0d got done=%b busy=%b want 00/0", i, bus.done, bus.busy);
         end
      end
   endtask
   initial begin
      test_reset();
      test_idle_commit();
      test_mid_frame();
      test_back_to_back();
      test_timeout();
      test_clear_and_reset();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end
endmodule
